// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared definitions for the multicycle MIPS controller.
// It holds the state encoding, the opcode constants, the ALUOp codes (the
// ALUControl block consumes these as well), the ALUSrcB/PCSource mux
// encodings and the DECODE dispatch helper.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADDR  = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      RTYPE_EX = 4'd6,
      RTYPE_WB = 4'd7,
      IMM_EX   = 4'd8,
      IMM_WB   = 4'd9,
      BRANCH   = 4'd10,
      JUMP     = 4'd11
   } state_t;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // ALUOp codes
   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_FUNCT = 3'b010;
   localparam logic [2:0] ALUOP_OR    = 3'b011;
   localparam logic [2:0] ALUOP_AND   = 3'b100;
   localparam logic [2:0] ALUOP_LUI   = 3'b101;

   // ALU B-operand select
   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_SIGNEXT = 2'b10;
   localparam logic [1:0] SRCB_SHIFTED = 2'b11;

   // Next-PC select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Target state leaving DECODE; FETCH means the opcode is not recognised.
   function automatic state_t decodeDispatch(input logic [5:0] opcode);
      case (opcode)
         OP_RTYPE:                         decodeDispatch = RTYPE_EX;
         OP_LW, OP_SW:                     decodeDispatch = MEMADDR;
         OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: decodeDispatch = IMM_EX;
         OP_BEQ, OP_BNE:                   decodeDispatch = BRANCH;
         OP_J:                             decodeDispatch = JUMP;
         default:                          decodeDispatch = FETCH;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_ctrl_decode: combinational strobe decoder, State+Opcode -> strobes.
// Ports: state/opcode/zero/memReady in; all datapath strobes plus the raw
// illegal and retire indications out. Reset gating is applied by the parent.
module multicycle_ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       memReady,
   output logic       pcWrite,
   output logic       iorD,
   output logic       memRead,
   output logic       memWrite,
   output logic       irWrite,
   output logic       regDst,
   output logic       memtoReg,
   output logic       regWrite,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [2:0] aluOp,
   output logic [1:0] pcSource,
   output logic       illegal,
   output logic       retire
);

   // Strobe decode; everything defaults to 0 and each state raises its own.
   always_comb begin
      pcWrite  = 1'b0;
      iorD     = 1'b0;
      memRead  = 1'b0;
      memWrite = 1'b0;
      irWrite  = 1'b0;
      regDst   = 1'b0;
      memtoReg = 1'b0;
      regWrite = 1'b0;
      aluSrcA  = 1'b0;
      aluSrcB  = SRCB_RT;
      aluOp    = ALUOP_ADD;
      pcSource = PCSRC_ALU;
      illegal  = 1'b0;
      retire   = 1'b0;
      case (state)
         FETCH: begin
            memRead = 1'b1;
            aluSrcB = SRCB_FOUR;
            // IR and PC load only on the cycle the memory delivers the word
            irWrite = memReady;
            pcWrite = memReady;
         end
         DECODE: begin
            aluSrcB = SRCB_SHIFTED;
            illegal = (decodeDispatch(opcode) == FETCH);
         end
         MEMADDR: begin
            aluSrcA = 1'b1;
            aluSrcB = SRCB_SIGNEXT;
         end
         MEMREAD: begin
            memRead = 1'b1;
            iorD    = 1'b1;
         end
         MEMWB: begin
            regWrite = 1'b1;
            memtoReg = 1'b1;
            retire   = 1'b1;
         end
         MEMWRITE: begin
            memWrite = 1'b1;
            iorD     = 1'b1;
            retire   = memReady;
         end
         RTYPE_EX: begin
            aluSrcA = 1'b1;
            aluOp   = ALUOP_FUNCT;
         end
         RTYPE_WB: begin
            regWrite = 1'b1;
            regDst   = 1'b1;
            retire   = 1'b1;
         end
         IMM_EX: begin
            aluSrcA = 1'b1;
            aluSrcB = SRCB_SIGNEXT;
            case (opcode)
               OP_ANDI: aluOp = ALUOP_AND;
               OP_ORI:  aluOp = ALUOP_OR;
               OP_LUI:  aluOp = ALUOP_LUI;
               default: aluOp = ALUOP_ADD;
            endcase
         end
         IMM_WB: begin
            regWrite = 1'b1;
            retire   = 1'b1;
         end
         BRANCH: begin
            aluSrcA  = 1'b1;
            aluOp    = ALUOP_SUB;
            pcSource = PCSRC_ALUOUT;
            pcWrite  = ((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero);
            retire   = 1'b1;
         end
         JUMP: begin
            pcSource = PCSRC_JUMP;
            pcWrite  = 1'b1;
            retire   = 1'b1;
         end
         default: begin
            retire = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle MIPS sequencer (FETCH..JUMP).
// Ports: clk, reset (sync, active-high), Opcode, Zero, MemReady in;
// datapath strobes, Illegal/InstrDone pulses, InstrCount and State out.
// Holds the state register, next-state logic and retired-instruction counter;
// strobe decode lives in multicycle_ctrl_decode.
module multicycle_controller
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [5:0]           Opcode,
   input  logic                 Zero,
   input  logic                 MemReady,
   output logic                 PCWrite,
   output logic                 IorD,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic                 RegDst,
   output logic                 MemtoReg,
   output logic                 RegWrite,
   output logic                 ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [2:0]           ALUOp,
   output logic [1:0]           PCSource,
   output logic                 Illegal,
   output logic                 InstrDone,
   output logic [CNT_WIDTH-1:0] InstrCount,
   output logic [3:0]           State
);

   state_t curState;
   state_t nextState;
   logic   pcWriteRaw;
   logic   memWriteRaw;
   logic   irWriteRaw;
   logic   regWriteRaw;
   logic   illegalRaw;
   logic   retireRaw;

   multicycle_ctrl_decode uDecode (
      .state    (curState),
      .opcode   (Opcode),
      .zero     (Zero),
      .memReady (MemReady),
      .pcWrite  (pcWriteRaw),
      .iorD     (IorD),
      .memRead  (MemRead),
      .memWrite (memWriteRaw),
      .irWrite  (irWriteRaw),
      .regDst   (RegDst),
      .memtoReg (MemtoReg),
      .regWrite (regWriteRaw),
      .aluSrcA  (ALUSrcA),
      .aluSrcB  (ALUSrcB),
      .aluOp    (ALUOp),
      .pcSource (PCSource),
      .illegal  (illegalRaw),
      .retire   (retireRaw)
   );

   // Architectural writes and pulses are suppressed while reset is held, so a
   // reset mid-instruction aborts it without side effects.
   always_comb begin
      PCWrite   = pcWriteRaw  & ~reset;
      MemWrite  = memWriteRaw & ~reset;
      IRWrite   = irWriteRaw  & ~reset;
      RegWrite  = regWriteRaw & ~reset;
      Illegal   = illegalRaw  & ~reset;
      InstrDone = retireRaw   & ~reset;
      State     = curState;
   end

   // Next-state logic; Opcode is consulted only from DECODE onward.
   always_comb begin
      nextState = FETCH;
      case (curState)
         FETCH:    nextState = MemReady ? DECODE : FETCH;
         DECODE:   nextState = decodeDispatch(Opcode);
         MEMADDR:  nextState = (Opcode == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD:  nextState = MemReady ? MEMWB : MEMREAD;
         MEMWRITE: nextState = MemReady ? FETCH : MEMWRITE;
         RTYPE_EX: nextState = RTYPE_WB;
         IMM_EX:   nextState = IMM_WB;
         default:  nextState = FETCH;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         curState <= FETCH;
      end else begin
         curState <= nextState;
      end
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_WIDTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         InstrCount <= {CNT_WIDTH{1'b0}};
      end else if (retireRaw) begin
         InstrCount <= InstrCount + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         InstrCount <= InstrCount;
      end
   end

endmodule
